// File: rtl/cpu_seq_pkg.sv
// Shared definitions for the instruction sequencer: opcodes, instruction
// field positions and the control FSM encoding.
package cpu_seq_pkg;

  localparam logic [3:0]  OP_HLT    = 4'b1111;
  localparam logic [3:0]  OP_IDLE   = 4'b0110;
  localparam logic [15:0] INSTR_HLT = 16'hF000;

  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 12;
  localparam int ADR_MSB = 11;
  localparam int ADR_LSB = 8;
  localparam int OPR_MSB = 7;
  localparam int OPR_LSB = 0;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_ISSUE   = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_DONE    = 3'd4
  } seq_state_e;

  function automatic logic is_hlt(input logic [15:0] instr);
    return (instr[OPC_MSB:OPC_LSB] == OP_HLT);
  endfunction

endpackage

// File: rtl/seq_imem.sv
// Instruction store: DEPTH x 16 register file, synchronous write,
// combinational read, every entry reset to HLT.
module seq_imem
  import cpu_seq_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int PC_W  = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            we_i,
  input  logic [PC_W-1:0] waddr_i,
  input  logic [15:0]     wdata_i,
  input  logic [PC_W-1:0] raddr_i,
  output logic [15:0]     rdata_o
);

  logic [15:0] mem_q [DEPTH];

  // Storage array with reset-to-HLT so an unprogrammed run halts immediately
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= INSTR_HLT;
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/cpu_sequencer.sv
// Steps through the instruction store, issuing one instruction to the CPU
// datapath every three cycles and capturing its result and flags.
module cpu_sequencer
  import cpu_seq_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int PC_W  = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            abort,
  input  logic            prog_we,
  input  logic [PC_W-1:0] prog_addr,
  input  logic [15:0]     prog_data,
  output logic [3:0]      cpu_opcode,
  output logic [3:0]      cpu_address,
  output logic [7:0]      cpu_myinput,
  input  logic [7:0]      cpu_myoutput,
  input  logic [2:0]      cpu_flags,
  output logic            busy,
  output logic            done,
  output logic            aborted,
  output logic            halted_by_hlt,
  output logic            trace_valid,
  output logic [PC_W-1:0] pc,
  output logic [PC_W:0]   instr_count,
  output logic [7:0]      result,
  output logic [2:0]      result_flags
);

  localparam logic [PC_W-1:0] PC_LAST  = PC_W'(DEPTH - 1);
  localparam logic [PC_W-1:0] PC_ZERO  = {PC_W{1'b0}};
  localparam logic [PC_W-1:0] PC_ONE   = {{(PC_W-1){1'b0}}, 1'b1};
  localparam logic [PC_W:0]   CNT_ZERO = {(PC_W+1){1'b0}};
  localparam logic [PC_W:0]   CNT_ONE  = {{PC_W{1'b0}}, 1'b1};

  seq_state_e      state_q, state_d;
  logic [15:0]     ir_q, ir_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W:0]   count_q, count_d;
  logic [7:0]      result_q, result_d;
  logic [2:0]      flags_q, flags_d;
  logic            halted_q, halted_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            aborted_q, aborted_d;
  logic            trace_q, trace_d;
  logic [3:0]      cpu_op_q, cpu_op_d;
  logic [3:0]      cpu_addr_q, cpu_addr_d;
  logic [7:0]      cpu_in_q, cpu_in_d;
  logic [15:0]     imem_rdata_s;
  logic            imem_we_s;

  // Program writes are only accepted while no run is in flight
  assign imem_we_s = prog_we && ((state_q == ST_IDLE) || (state_q == ST_DONE));

  seq_imem #(
    .DEPTH (DEPTH),
    .PC_W  (PC_W)
  ) u_imem (
    .clk     (clk),
    .rst     (rst),
    .we_i    (imem_we_s),
    .waddr_i (prog_addr),
    .wdata_i (prog_data),
    .raddr_i (pc_q),
    .rdata_o (imem_rdata_s)
  );

  // Next-state and next-output logic; CPU vector is prepared in FETCH so it is registered during ISSUE
  always_comb begin
    state_d    = state_q;
    ir_d       = ir_q;
    pc_d       = pc_q;
    count_d    = count_q;
    result_d   = result_q;
    flags_d    = flags_q;
    halted_d   = halted_q;
    aborted_d  = 1'b0;
    trace_d    = 1'b0;
    cpu_op_d   = OP_IDLE;
    cpu_addr_d = 4'h0;
    cpu_in_d   = 8'h00;
    case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          state_d  = ST_FETCH;
          pc_d     = PC_ZERO;
          count_d  = CNT_ZERO;
          halted_d = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FETCH: begin
        if (abort) begin
          state_d   = ST_IDLE;
          aborted_d = 1'b1;
        end else begin
          state_d = ST_ISSUE;
          ir_d    = imem_rdata_s;
          if (!is_hlt(imem_rdata_s)) begin
            cpu_op_d   = imem_rdata_s[OPC_MSB:OPC_LSB];
            cpu_addr_d = imem_rdata_s[ADR_MSB:ADR_LSB];
            cpu_in_d   = imem_rdata_s[OPR_MSB:OPR_LSB];
          end else begin
            cpu_op_d = OP_IDLE;
          end
        end
      end
      ST_ISSUE: begin
        if (abort) begin
          state_d   = ST_IDLE;
          aborted_d = 1'b1;
        end else if (is_hlt(ir_q)) begin
          state_d  = ST_DONE;
          halted_d = 1'b1;
        end else begin
          state_d = ST_CAPTURE;
          count_d = count_q + CNT_ONE;
        end
      end
      ST_CAPTURE: begin
        if (abort) begin
          state_d   = ST_IDLE;
          aborted_d = 1'b1;
        end else begin
          result_d = cpu_myoutput;
          flags_d  = cpu_flags;
          trace_d  = 1'b1;
          if (pc_q == PC_LAST) begin
            pc_d    = PC_ZERO;
            state_d = ST_DONE;
          end else begin
            pc_d    = pc_q + PC_ONE;
            state_d = ST_FETCH;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d == ST_FETCH) || (state_d == ST_ISSUE) || (state_d == ST_CAPTURE);
    done_d = (state_d == ST_DONE);
  end

  // State, datapath and output registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      ir_q       <= INSTR_HLT;
      pc_q       <= PC_ZERO;
      count_q    <= CNT_ZERO;
      result_q   <= 8'h00;
      flags_q    <= 3'b000;
      halted_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      aborted_q  <= 1'b0;
      trace_q    <= 1'b0;
      cpu_op_q   <= OP_IDLE;
      cpu_addr_q <= 4'h0;
      cpu_in_q   <= 8'h00;
    end else begin
      state_q    <= state_d;
      ir_q       <= ir_d;
      pc_q       <= pc_d;
      count_q    <= count_d;
      result_q   <= result_d;
      flags_q    <= flags_d;
      halted_q   <= halted_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      aborted_q  <= aborted_d;
      trace_q    <= trace_d;
      cpu_op_q   <= cpu_op_d;
      cpu_addr_q <= cpu_addr_d;
      cpu_in_q   <= cpu_in_d;
    end
  end

  assign cpu_opcode    = cpu_op_q;
  assign cpu_address   = cpu_addr_q;
  assign cpu_myinput   = cpu_in_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign aborted       = aborted_q;
  assign halted_by_hlt = halted_q;
  assign trace_valid   = trace_q;
  assign pc            = pc_q;
  assign instr_count   = count_q;
  assign result        = result_q;
  assign result_flags  = flags_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench for cpu_sequencer: a scoreboard holds expected CPU
// issues and captured results; scenario tasks check status and timing.
module tb_cpu_sequencer;

  logic        clk;
  logic        rst;
  logic        start;
  logic        abort;
  logic        prog_we;
  logic [3:0]  prog_addr;
  logic [15:0] prog_data;
  logic [3:0]  cpu_opcode;
  logic [3:0]  cpu_address;
  logic [7:0]  cpu_myinput;
  logic [7:0]  cpu_myoutput;
  logic [2:0]  cpu_flags;
  logic        busy, done, aborted, halted_by_hlt, trace_valid;
  logic [3:0]  pc;
  logic [4:0]  instr_count;
  logic [7:0]  result;
  logic [2:0]  result_flags;

  int vectors     = 0;
  int miscompares = 0;
  int issue_cnt   = 0;
  int trace_cnt   = 0;
  int done_cnt    = 0;
  int abort_cnt   = 0;
  bit mon_en      = 1'b0;

  logic [15:0] exp_issue_q[$];
  logic [10:0] exp_res_q[$];

  cpu_sequencer #(.DEPTH(16), .PC_W(4)) dut (
    .clk (clk), .rst (rst), .start (start), .abort (abort),
    .prog_we (prog_we), .prog_addr (prog_addr), .prog_data (prog_data),
    .cpu_opcode (cpu_opcode), .cpu_address (cpu_address), .cpu_myinput (cpu_myinput),
    .cpu_myoutput (cpu_myoutput), .cpu_flags (cpu_flags),
    .busy (busy), .done (done), .aborted (aborted), .halted_by_hlt (halted_by_hlt),
    .trace_valid (trace_valid), .pc (pc), .instr_count (instr_count),
    .result (result), .result_flags (result_flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [2:0] model_flags(input logic [7:0] v);
    return {v[7], (v == 8'h00), v[0]};
  endfunction

  // Toy CPU: one-cycle pass-through of the operand, flags {sign, zero, lsb}
  always @(posedge clk) begin
    cpu_myoutput <= cpu_myinput;
    cpu_flags    <= model_flags(cpu_myinput);
  end

  // Scoreboard monitor: any non-idle CPU vector is an issue, trace_valid is a capture
  always @(negedge clk) begin
    if (mon_en) begin
      if ({cpu_opcode, cpu_address, cpu_myinput} !== 16'h6000) begin
        issue_cnt++;
        vectors++;
        if (exp_issue_q.size() == 0) begin
          miscompares++;
          $display("FAIL issue_unexpected got=%h", {cpu_opcode, cpu_address, cpu_myinput});
        end else begin
          logic [15:0] e;
          e = exp_issue_q.pop_front();
          if ({cpu_opcode, cpu_address, cpu_myinput} !== e) begin
            miscompares++;
            $display("FAIL issue_vector got=%h exp=%h", {cpu_opcode, cpu_address, cpu_myinput}, e);
          end
        end
      end
      if (trace_valid === 1'b1) begin
        trace_cnt++;
        vectors++;
        if (exp_res_q.size() == 0) begin
          miscompares++;
          $display("FAIL trace_unexpected got=%h", {result_flags, result});
        end else begin
          logic [10:0] r;
          r = exp_res_q.pop_front();
          if ({result_flags, result} !== r) begin
            miscompares++;
            $display("FAIL trace_result got=%h exp=%h", {result_flags, result}, r);
          end
        end
      end
      if (done === 1'b1) done_cnt++;
      if (aborted === 1'b1) abort_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  task automatic prog_write(input logic [3:0] a, input logic [15:0] d);
    prog_we   = 1'b1;
    prog_addr = a;
    prog_data = d;
    tick();
    prog_we   = 1'b0;
  endtask

  task automatic push_instr(input logic [15:0] d);
    exp_issue_q.push_back(d);
    exp_res_q.push_back({model_flags(d[7:0]), d[7:0]});
  endtask

  task automatic wait_done(input int cyc0, output int cyc);
    cyc = cyc0;
    while (done !== 1'b1 && cyc < 200) begin
      tick();
      cyc++;
    end
    if (done !== 1'b1) begin
      vectors++;
      miscompares++;
      $display("FAIL done_timeout got=%0d cycles exp=done pulse", cyc);
    end
  endtask

  task automatic start_and_wait(output int cyc);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(1, cyc);
  endtask

  task automatic check_drained(input string name);
    vectors++;
    if (exp_issue_q.size() != 0 || exp_res_q.size() != 0) begin
      miscompares++;
      $display("FAIL %s_drained got=%0d/%0d pending exp=0/0", name, exp_issue_q.size(), exp_res_q.size());
      exp_issue_q.delete();
      exp_res_q.delete();
    end
  endtask

  task automatic test_reset();
    apply_reset();
    vectors++;
    if ({busy, done, aborted, halted_by_hlt, trace_valid} !== 5'b0) begin
      miscompares++;
      $display("FAIL reset_status got=%b exp=00000", {busy, done, aborted, halted_by_hlt, trace_valid});
    end
    vectors++;
    if ({pc, instr_count, result, result_flags} !== 20'h0) begin
      miscompares++;
      $display("FAIL reset_regs got=%h exp=0", {pc, instr_count, result, result_flags});
    end
    vectors++;
    if ({cpu_opcode, cpu_address, cpu_myinput} !== 16'h6000) begin
      miscompares++;
      $display("FAIL reset_cpu_idle got=%h exp=6000", {cpu_opcode, cpu_address, cpu_myinput});
    end
    mon_en = 1'b1;
  endtask

  task automatic test_single_hlt();
    int cyc;
    apply_reset();
    prog_write(4'd0, 16'h5503);
    prog_write(4'd1, 16'hF000);
    push_instr(16'h5503);
    start_and_wait(cyc);
    // FETCH is cycle 1: FETCH ISSUE CAPTURE FETCH ISSUE(HLT) DONE
    vectors++;
    if (cyc !== 6) begin
      miscompares++;
      $display("FAIL hlt_done_latency got=%0d exp=6", cyc);
    end
    vectors++;
    if ({halted_by_hlt, busy, instr_count, pc} !== {1'b1, 1'b0, 5'd1, 4'd1}) begin
      miscompares++;
      $display("FAIL hlt_status got=%b/%b/%0d/%0d exp=1/0/1/1", halted_by_hlt, busy, instr_count, pc);
    end
    vectors++;
    if ({result_flags, result} !== {3'b001, 8'h03}) begin
      miscompares++;
      $display("FAIL hlt_result got=%h exp=103", {result_flags, result});
    end
    tick();
    vectors++;
    if (done !== 1'b0 || halted_by_hlt !== 1'b1) begin
      miscompares++;
      $display("FAIL hlt_done_pulse got=done%b halted%b exp=done0 halted1", done, halted_by_hlt);
    end
    check_drained("hlt");
  endtask

  task automatic test_program_patterns();
    int cyc;
    logic [15:0] prog [4];
    prog[0] = 16'h1A7F; prog[1] = 16'h2B80; prog[2] = 16'h3C00; prog[3] = 16'h4DFF;
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      prog_write(4'(i), prog[i]);
      push_instr(prog[i]);
    end
    start_and_wait(cyc);
    vectors++;
    if (cyc !== 15) begin
      miscompares++;
      $display("FAIL pattern_latency got=%0d exp=15", cyc);
    end
    vectors++;
    if ({result_flags, result, instr_count, pc, halted_by_hlt} !== {3'b101, 8'hFF, 5'd4, 4'd4, 1'b1}) begin
      miscompares++;
      $display("FAIL pattern_final got=%b/%h/%0d/%0d/%b exp=101/ff/4/4/1",
               result_flags, result, instr_count, pc, halted_by_hlt);
    end
    check_drained("pattern");
  endtask

  task automatic test_full_run();
    int cyc;
    apply_reset();
    for (int i = 0; i < 16; i++) begin
      prog_write(4'(i), 16'h6200);
      push_instr(16'h6200);
    end
    trace_cnt = 0;
    done_cnt  = 0;
    start_and_wait(cyc);
    tick();
    vectors++;
    if (trace_cnt !== 16 || done_cnt !== 1) begin
      miscompares++;
      $display("FAIL full_counts got=trace%0d done%0d exp=trace16 done1", trace_cnt, done_cnt);
    end
    vectors++;
    if ({halted_by_hlt, instr_count, pc, result_flags} !== {1'b0, 5'd16, 4'd0, 3'b010}) begin
      miscompares++;
      $display("FAIL full_final got=%b/%0d/%0d/%b exp=0/16/0/010", halted_by_hlt, instr_count, pc, result_flags);
    end
    check_drained("full");
  endtask

  task automatic test_abort();
    apply_reset();
    prog_write(4'd0, 16'h1111);
    prog_write(4'd1, 16'h1222);
    prog_write(4'd2, 16'h1333);
    push_instr(16'h1111);
    exp_issue_q.push_back(16'h1222);
    done_cnt  = 0;
    abort_cnt = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 2; k <= 6; k++) tick();
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL abort_pre_busy got=%b exp=1", busy);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    vectors++;
    if ({aborted, busy, done, instr_count, result} !== {1'b1, 1'b0, 1'b0, 5'd2, 8'h11}) begin
      miscompares++;
      $display("FAIL abort_state got=%b/%b/%b/%0d/%h exp=1/0/0/2/11", aborted, busy, done, instr_count, result);
    end
    tick();
    tick();
    tick();
    vectors++;
    if (aborted !== 1'b0 || done_cnt !== 0 || abort_cnt !== 1) begin
      miscompares++;
      $display("FAIL abort_pulse got=aborted%b done%0d pulses%0d exp=0/0/1", aborted, done_cnt, abort_cnt);
    end
    check_drained("abort");
  endtask

  task automatic test_abort_start_idle();
    int base_issue;
    base_issue = issue_cnt;
    abort_cnt  = 0;
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    vectors++;
    if (busy !== 1'b0 || aborted !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_start_idle got=busy%b aborted%b exp=0/0", busy, aborted);
    end
    for (int k = 0; k < 4; k++) tick();
    vectors++;
    if (issue_cnt !== base_issue || abort_cnt !== 0) begin
      miscompares++;
      $display("FAIL abort_start_quiet got=%0d issues %0d aborts exp=%0d/0", issue_cnt, abort_cnt, base_issue);
    end
  endtask

  task automatic test_busy_ignores();
    int cyc;
    int base_issue;
    apply_reset();
    prog_write(4'd0, 16'h7123);
    push_instr(16'h7123);
    base_issue = issue_cnt;
    done_cnt   = 0;
    start = 1'b1;
    tick();
    prog_we   = 1'b1;
    prog_addr = 4'd0;
    prog_data = 16'h0000;
    tick();
    tick();
    tick();
    start   = 1'b0;
    prog_we = 1'b0;
    wait_done(4, cyc);
    tick();
    vectors++;
    if (done_cnt !== 1 || issue_cnt !== base_issue + 1 || instr_count !== 5'd1) begin
      miscompares++;
      $display("FAIL busy_ignore_run got=done%0d issues%0d count%0d exp=1/%0d/1",
               done_cnt, issue_cnt, instr_count, base_issue + 1);
    end
    push_instr(16'h7123);
    start_and_wait(cyc);
    vectors++;
    if (cyc !== 6 || issue_cnt !== base_issue + 2 || result !== 8'h23) begin
      miscompares++;
      $display("FAIL busy_ignore_rerun got=cyc%0d issues%0d res%h exp=6/%0d/23", cyc, issue_cnt, result, base_issue + 2);
    end
    check_drained("busy_ignore");
  endtask

  task automatic test_back_to_back();
    int cyc;
    apply_reset();
    // write and start on the same edge: the fresh entry must be fetched
    prog_we   = 1'b1;
    prog_addr = 4'd0;
    prog_data = 16'h8456;
    start     = 1'b1;
    push_instr(16'h8456);
    tick();
    prog_we = 1'b0;
    start   = 1'b0;
    wait_done(1, cyc);
    tick();
    push_instr(16'h8456);
    start_and_wait(cyc);
    vectors++;
    if (instr_count !== 5'd1 || result !== 8'h56 || halted_by_hlt !== 1'b1) begin
      miscompares++;
      $display("FAIL back_to_back got=%0d/%h/%b exp=1/56/1", instr_count, result, halted_by_hlt);
    end
    check_drained("back_to_back");
  endtask

  task automatic test_reset_mid_run();
    int cyc;
    apply_reset();
    prog_write(4'd0, 16'h9ABC);
    prog_write(4'd5, 16'h1234);
    exp_issue_q.push_back(16'h9ABC);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    vectors++;
    if ({busy, pc, instr_count, result, halted_by_hlt} !== 19'h0) begin
      miscompares++;
      $display("FAIL midrst_regs got=%b/%0d/%0d/%h/%b exp=0", busy, pc, instr_count, result, halted_by_hlt);
    end
    vectors++;
    if ({cpu_opcode, cpu_address, cpu_myinput} !== 16'h6000) begin
      miscompares++;
      $display("FAIL midrst_cpu_idle got=%h exp=6000", {cpu_opcode, cpu_address, cpu_myinput});
    end
    for (int i = 0; i < 16; i++) begin
      vectors++;
      if (dut.u_imem.mem_q[i] !== 16'hF000) begin
        miscompares++;
        $display("FAIL midrst_imem[%0d] got=%h exp=f000", i, dut.u_imem.mem_q[i]);
      end
    end
    start_and_wait(cyc);
    vectors++;
    if (cyc !== 3 || halted_by_hlt !== 1'b1 || instr_count !== 5'd0) begin
      miscompares++;
      $display("FAIL midrst_hlt_run got=cyc%0d halted%b count%0d exp=3/1/0", cyc, halted_by_hlt, instr_count);
    end
    check_drained("midrst");
  endtask

  initial begin
    rst       = 1'b0;
    start     = 1'b0;
    abort     = 1'b0;
    prog_we   = 1'b0;
    prog_addr = 4'd0;
    prog_data = 16'h0000;
    test_reset();
    test_single_hlt();
    test_program_patterns();
    test_full_run();
    test_abort();
    test_abort_start_idle();
    test_busy_ignores();
    test_back_to_back();
    test_reset_mid_run();
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
